mpu_load_unit: RTL and testbench
================================

Name: mpu_load_unit

Overview:
- Load stage of the MPU: accepts a matrix descriptor and a row-major element stream from memory or the testbench over an en/ack handshake.
- Writes each element, tagged with its (m,n) location, into the matrix register file at the selected register address.
- Sits between the external load source and the matrix register file. Its outputs feed the register-file write port.

Parameters:
FP, 32, float element width in bits (32 or 64)
M, 4, max matrix rows
N, 4, max matrix columns
MBITS, $clog2(M), row index width minus one
NBITS, $clog2(N), column index width minus one
MATRIX_REG_SIZE, 3, register-file address width

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active high
en  input  1  load request; held high for the whole transfer
valid  input  1  element qualifier; element sampled when en && ack && valid
element  input  FP  matrix element, row-major order
matrix_m_size  input  MBITS+1  row count, sampled at start
matrix_n_size  input  NBITS+1  column count, sampled at start
load_addr  input  MATRIX_REG_SIZE  destination register, sampled at start
ack  output  1  high while the unit accepts elements
error  output  1  bad descriptor (or bad element with the option); held until en low
done  output  1  one-cycle pulse after the last element is written
write_en  output  1  register-file write strobe
reg_load_addr  output  MATRIX_REG_SIZE  register-file destination
element_out  output  FP  element being written
m  output  MBITS+1  row of element_out
n  output  NBITS+1  column of element_out

Behaviour:
- One clock domain, clk. Reset is synchronous and active high (rst). All outputs are registered.
- Reset values: ack=0, error=0, done=0, write_en=0, reg_load_addr=0, element_out=0, m=0, n=0. State is IDLE.
- Reset mid-transfer aborts immediately. Elements already written stay written. No done pulse.
- IDLE:
  - On en=1, latch the sizes and load_addr.
  - Descriptor is legal when 1<=m_size<=M and 1<=n_size<=N.
  - Legal: go to LOAD; ack=1 from the next cycle.
  - Illegal: go to ERR.
- LOAD:
  - Each cycle with valid=1, the element is accepted. The next cycle shows write_en=1, element_out=element, m/n=current counters, reg_load_addr=latched address. Latency is 1 cycle.
  - valid=0: write_en=0 and counters hold. Gaps of any length are allowed.
  - Counters advance row-major: n increments; at n=n_size-1, n wraps to 0 and m increments.
  - Accepting element (m_size-1, n_size-1) ends the transfer. ack drops in the same cycle the final write_en is asserted, done pulses on the following cycle, and the state goes to DONE.
  - en dropping in LOAD aborts to IDLE next cycle: ack=0, no done, no further writes.
- DONE: ack=0; wait for en=0, then IDLE. en held high must not restart a transfer.
- ERR: error=1, ack=0, no writes. On en=0, error clears next cycle and state goes to IDLE.
- valid while ack=0 is ignored.
- The latched size is used for the whole transfer; size inputs may change after start.
- The 1x1 matrix is legal: a single write, then done.

Optional Feature:
MPU_LOAD_NANCHECK_EN:
- Defined: an accepted element whose exponent field is all ones (bits 30:23 for FP=32, bits 62:52 for FP=64) is not written. The unit enters ERR with error=1 and ack=0 on the next cycle. Earlier elements remain written.
- Undefined: elements are written unchecked and no exponent logic is synthesized.

Test Plan:
- 2x2 load, addr=3, elements 1.0,2.0,3.0,4.0 (0x3F800000...0x40800000), valid every cycle -> four write_en pulses at (0,0),(0,1),(1,0),(1,1) with addr=3, each 1 cycle after acceptance; done pulses once; ack=0 afterwards.
- 3x4 load with valid toggling 1,0,1,0 -> exactly 12 writes in row-major order; m/n never exceed 2/3; write_en never asserted for a valid=0 cycle.
- Descriptor m_size=0, then a separate run with n_size=N+1 -> error=1 within 1 cycle, ack stays 0, no writes; error clears 1 cycle after en=0.
- rst pulsed after 2 elements of a 2x2 load -> all outputs at reset values on the next cycle. A following 1x1 load to addr=1 completes with one write at (0,0).
- en dropped after 3 of 4 elements, then en held high after done in a second run -> abort with no done; no second transfer until en toggles low.
- With MPU_LOAD_NANCHECK_EN: 2x2 load whose second element is 0x7FC00000 -> one write only, then error=1 and ack=0. Without the macro: four writes and done.

Source files
------------

// File: rtl/mpu_load_unit_if.sv
// Load-stage bus for mpu_load_unit: descriptor/element handshake from the load
// source plus the register-file write port driven back by the unit.
interface mpu_load_unit_if #(
    parameter int FP              = 32,
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int MBITS           = $clog2(M),
    parameter int NBITS           = $clog2(N),
    parameter int MATRIX_REG_SIZE = 3
);
    logic                       en;
    logic                       valid;
    logic [FP-1:0]              element;
    logic [MBITS:0]             matrix_m_size;
    logic [NBITS:0]             matrix_n_size;
    logic [MATRIX_REG_SIZE-1:0] load_addr;

    logic                       ack;
    logic                       error;
    logic                       done;
    logic                       write_en;
    logic [MATRIX_REG_SIZE-1:0] reg_load_addr;
    logic [FP-1:0]              element_out;
    logic [MBITS:0]             m;
    logic [NBITS:0]             n;

    modport slave (
        input  en, valid, element, matrix_m_size, matrix_n_size, load_addr,
        output ack, error, done, write_en, reg_load_addr, element_out, m, n
    );

    modport master (
        output en, valid, element, matrix_m_size, matrix_n_size, load_addr,
        input  ack, error, done, write_en, reg_load_addr, element_out, m, n
    );
endinterface

// File: rtl/mpu_load_unit.sv
// MPU load stage: streams a row-major matrix into the register-file write port.
// Optional MPU_LOAD_NANCHECK_EN rejects elements with an all-ones exponent.
module mpu_load_unit #(
    parameter int FP              = 32,
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int MBITS           = $clog2(M),
    parameter int NBITS           = $clog2(N),
    parameter int MATRIX_REG_SIZE = 3
) (
    input logic          clk,
    input logic          rst,
    mpu_load_unit_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, FINISH, DONE, ERR} state_t;

    localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
    localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);
    localparam logic [MBITS:0] M_ONE = (MBITS+1)'(1);
    localparam logic [NBITS:0] N_ONE = (NBITS+1)'(1);

    state_t                     state;
    logic [MBITS:0]             m_size_q;
    logic [NBITS:0]             n_size_q;
    logic [MATRIX_REG_SIZE-1:0] addr_q;
    logic [MBITS:0]             cnt_m;
    logic [NBITS:0]             cnt_n;

    logic legal;
    logic row_end;
    logic last;
    logic bad_elem;

    always_comb begin
        legal   = (bus.matrix_m_size != '0) && (bus.matrix_m_size <= M_MAX) &&
                  (bus.matrix_n_size != '0) && (bus.matrix_n_size <= N_MAX);
        row_end = (cnt_n == n_size_q - N_ONE);
        last    = row_end && (cnt_m == m_size_q - M_ONE);
    end

`ifdef MPU_LOAD_NANCHECK_EN
    localparam int EXP_LSB = (FP == 64) ? 52 : 23;
    localparam int EXP_W   = (FP == 64) ? 11 : 8;
    assign bad_elem = &bus.element[EXP_LSB +: EXP_W];
`else
    assign bad_elem = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            m_size_q          <= '0;
            n_size_q          <= '0;
            addr_q            <= '0;
            cnt_m             <= '0;
            cnt_n             <= '0;
            bus.ack           <= 1'b0;
            bus.error         <= 1'b0;
            bus.done          <= 1'b0;
            bus.write_en      <= 1'b0;
            bus.reg_load_addr <= '0;
            bus.element_out   <= '0;
            bus.m             <= '0;
            bus.n             <= '0;
        end else begin
            bus.write_en <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        m_size_q <= bus.matrix_m_size;
                        n_size_q <= bus.matrix_n_size;
                        addr_q   <= bus.load_addr;
                        cnt_m    <= '0;
                        cnt_n    <= '0;
                        if (legal) begin
                            state   <= LOAD;
                            bus.ack <= 1'b1;
                        end else begin
                            state     <= ERR;
                            bus.error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (!bus.en) begin
                        state   <= IDLE;
                        bus.ack <= 1'b0;
                    end else if (bus.valid) begin
                        if (bad_elem) begin
                            state     <= ERR;
                            bus.error <= 1'b1;
                            bus.ack   <= 1'b0;
                        end else begin
                            bus.write_en      <= 1'b1;
                            bus.element_out   <= bus.element;
                            bus.reg_load_addr <= addr_q;
                            bus.m             <= cnt_m;
                            bus.n             <= cnt_n;
                            // Final element: ack falls alongside its write, done follows.
                            if (last) begin
                                state   <= FINISH;
                                bus.ack <= 1'b0;
                            end else if (row_end) begin
                                cnt_n <= '0;
                                cnt_m <= cnt_m + M_ONE;
                            end else begin
                                cnt_n <= cnt_n + N_ONE;
                            end
                        end
                    end
                end
                FINISH: begin
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (!bus.en) state <= IDLE;
                end
                ERR: begin
                    if (!bus.en) begin
                        bus.error <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_load_unit.sv
// Directed self-checking bench for mpu_load_unit; adapts the NaN-element case
// to whether MPU_LOAD_NANCHECK_EN is defined.
module tb_mpu_load_unit;

    localparam int FP    = 32;
    localparam int M     = 4;
    localparam int N     = 4;
    localparam int MBITS = $clog2(M);
    localparam int NBITS = $clog2(N);
    localparam int RS    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared   = 0;
    int mismatched = 0;
    int doneCount  = 0;
    logic [63:0] writeLog[$];

    mpu_load_unit_if #(.FP(FP), .M(M), .N(N), .MATRIX_REG_SIZE(RS)) bus();

    mpu_load_unit #(.FP(FP), .M(M), .N(N), .MATRIX_REG_SIZE(RS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack(input logic [2:0] a, input logic [2:0] mm,
                                         input logic [2:0] nn, input logic [31:0] d);
        return {23'd0, a, mm, nn, d};
    endfunction

    // Record every register-file write and done pulse mid-cycle.
    always @(negedge clk) begin
        if (bus.write_en) writeLog.push_back(pack(bus.reg_load_addr, bus.m, bus.n, bus.element_out));
        if (bus.done) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] data);
        bus.valid   = 1'b1;
        bus.element = data;
        step();
        bus.valid = 1'b0;
    endtask

    task automatic startLoad(input int ms, input int ns, input int addr);
        bus.matrix_m_size = 3'(ms);
        bus.matrix_n_size = 3'(ns);
        bus.load_addr     = 3'(addr);
        bus.en            = 1'b1;
        step();
    endtask

    task automatic endLoad();
        bus.en    = 1'b0;
        bus.valid = 1'b0;
        step();
    endtask

    task automatic clearLog();
        writeLog.delete();
        doneCount = 0;
    endtask

    function automatic logic [63:0] logAt(input int i);
        return (i < writeLog.size()) ? writeLog[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    logic [31:0] t1Data[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [2:0]  t1M[4]    = '{3'd0, 3'd0, 3'd1, 3'd1};
    logic [2:0]  t1N[4]    = '{3'd0, 3'd1, 3'd0, 3'd1};

    initial begin
        bus.en = 1'b0; bus.valid = 1'b0; bus.element = '0;
        bus.matrix_m_size = '0; bus.matrix_n_size = '0; bus.load_addr = '0;
        step(); step();
        checkOutput("reset_ack", bus.ack, 0);
        checkOutput("reset_error", bus.error, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_we", bus.write_en, 0);
        checkOutput("reset_bus", pack(bus.reg_load_addr, bus.m, bus.n, bus.element_out), 0);
        rst = 1'b0;
        step();

        // 2x2 load to addr 3, valid every cycle
        clearLog();
        startLoad(2, 2, 3);
        checkOutput("t1_ack_start", bus.ack, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(t1Data[i]);
            checkOutput($sformatf("t1_we%0d", i), bus.write_en, 1);
            checkOutput($sformatf("t1_wr%0d", i), pack(bus.reg_load_addr, bus.m, bus.n, bus.element_out),
                        pack(3'd3, t1M[i], t1N[i], t1Data[i]));
        end
        checkOutput("t1_ack_last", bus.ack, 0);
        step();
        checkOutput("t1_done", bus.done, 1);
        checkOutput("t1_we_after", bus.write_en, 0);
        step();
        checkOutput("t1_done_once", bus.done, 0);
        checkOutput("t1_ack_after", bus.ack, 0);
        endLoad();
        checkOutput("t1_writes", writeLog.size(), 4);
        checkOutput("t1_done_count", doneCount, 1);

        // 3x4 load, valid toggling, size inputs changed after start
        clearLog();
        startLoad(3, 4, 6);
        bus.matrix_m_size = 3'd1;
        bus.matrix_n_size = 3'd1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(32'h1000 + 32'(i));
            checkOutput($sformatf("t2_we_valid%0d", i), bus.write_en, 1);
            step();
            checkOutput($sformatf("t2_we_gap%0d", i), bus.write_en, 0);
        end
        checkOutput("t2_done", bus.done, 1);
        endLoad();
        checkOutput("t2_writes", writeLog.size(), 12);
        for (int i = 0; i < 12; i++)
            checkOutput($sformatf("t2_log%0d", i), logAt(i),
                        pack(3'd6, 3'(i / 4), 3'(i % 4), 32'h1000 + 32'(i)));
        checkOutput("t2_done_count", doneCount, 1);

        // Illegal descriptors: m_size=0, then n_size=N+1
        clearLog();
        for (int r = 0; r < 2; r++) begin
            bus.valid = 1'b1;
            if (r == 0) startLoad(0, 2, 5);
            else        startLoad(2, N + 1, 5);
            checkOutput($sformatf("t3_err%0d", r), bus.error, 1);
            checkOutput($sformatf("t3_ack%0d", r), bus.ack, 0);
            step(); step();
            checkOutput($sformatf("t3_err_hold%0d", r), bus.error, 1);
            checkOutput($sformatf("t3_ack_hold%0d", r), bus.ack, 0);
            endLoad();
            checkOutput($sformatf("t3_err_clear%0d", r), bus.error, 0);
        end
        checkOutput("t3_writes", writeLog.size(), 0);

        // Reset mid-transfer, then a 1x1 load
        clearLog();
        startLoad(2, 2, 2);
        applyStimulus(32'hAAAA0001);
        applyStimulus(32'hAAAA0002);
        rst    = 1'b1;
        bus.en = 1'b0;
        step();
        checkOutput("t4_rst_flags", {bus.ack, bus.error, bus.done, bus.write_en}, 0);
        checkOutput("t4_rst_bus", pack(bus.reg_load_addr, bus.m, bus.n, bus.element_out), 0);
        rst = 1'b0;
        step();
        checkOutput("t4_no_done", doneCount, 0);
        clearLog();
        startLoad(1, 1, 1);
        applyStimulus(32'h0000ABCD);
        checkOutput("t4_wr", pack(bus.reg_load_addr, bus.m, bus.n, bus.element_out), pack(3'd1, 3'd0, 3'd0, 32'h0000ABCD));
        checkOutput("t4_ack", bus.ack, 0);
        step();
        checkOutput("t4_done", bus.done, 1);
        endLoad();
        checkOutput("t4_writes", writeLog.size(), 1);

        // Abort after 3 of 4, then en held high after done
        clearLog();
        startLoad(2, 2, 4);
        for (int i = 0; i < 3; i++) applyStimulus(32'hB000 + 32'(i));
        endLoad();
        checkOutput("t5_abort_ack", bus.ack, 0);
        step(); step(); step();
        checkOutput("t5_abort_done", doneCount, 0);
        checkOutput("t5_abort_writes", writeLog.size(), 3);
        clearLog();
        startLoad(2, 2, 4);
        for (int i = 0; i < 4; i++) applyStimulus(32'hC000 + 32'(i));
        bus.valid = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checkOutput("t5_hold_ack", bus.ack, 0);
        checkOutput("t5_hold_writes", writeLog.size(), 4);
        checkOutput("t5_hold_done", doneCount, 1);
        endLoad();
        startLoad(1, 1, 0);
        checkOutput("t5_restart_ack", bus.ack, 1);
        endLoad();

        // Second element is a NaN
        clearLog();
        startLoad(2, 2, 2);
        applyStimulus(32'h3F800000);
        applyStimulus(32'h7FC00000);
`ifdef MPU_LOAD_NANCHECK_EN
        checkOutput("t6_err", bus.error, 1);
        checkOutput("t6_ack", bus.ack, 0);
        checkOutput("t6_we", bus.write_en, 0);
        applyStimulus(32'h40400000);
        endLoad();
        checkOutput("t6_err_clear", bus.error, 0);
        checkOutput("t6_writes", writeLog.size(), 1);
        checkOutput("t6_done_count", doneCount, 0);
`else
        checkOutput("t6_we", bus.write_en, 1);
        checkOutput("t6_wr", pack(bus.reg_load_addr, bus.m, bus.n, bus.element_out), pack(3'd2, 3'd0, 3'd1, 32'h7FC00000));
        applyStimulus(32'h40400000);
        applyStimulus(32'h40800000);
        step();
        endLoad();
        checkOutput("t6_writes", writeLog.size(), 4);
        checkOutput("t6_done_count", doneCount, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
